// File: rtl/cfg_bus_pkg.sv
// Shared types and widths for the configuration register bus arbiter.
package cfg_bus_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // One latched bus command plus the master that owns it.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
    logic              owner;
  } cmd_t;

endpackage

// File: rtl/cfg_bus_arb_rr_arb2.sv
// Two-request round-robin arbiter: purely combinational grant selection.
// On a tie the master that did not win last time is chosen; the caller
// registers last_grant_nxt_o to remember the winner.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       update_i,
  output logic       gnt_vld_o,
  output logic       gnt_o,
  output logic       last_grant_nxt_o
);

  // Pick the winner from the request pair and the previous winner.
  always_comb begin
    gnt_vld_o        = |req_i;
    gnt_o            = 1'b0;
    last_grant_nxt_o = last_grant_i;
    case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_grant_i;
      default: gnt_o = 1'b0;
    endcase
    if (update_i) begin
      last_grant_nxt_o = gnt_o;
    end else begin
      last_grant_nxt_o = last_grant_i;
    end
  end

endmodule

// File: rtl/cfg_bus_arb.sv
// Two-master arbiter for the configuration register bus. One transaction
// at a time; reads wait for the slave's valid pulse or time out with a
// fixed data word and a sticky flag. Every output comes from a register.
module cfg_bus_arb
  import cfg_bus_pkg::*;
#(
  parameter int                TIMEOUT_CYC  = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_wr_en,
  input  logic              m0_rd_en,
  input  logic [BE_W-1:0]   m0_byte_enable,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_wait_request,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rd_data_vld,
  input  logic              m1_wr_en,
  input  logic              m1_rd_en,
  input  logic [BE_W-1:0]   m1_byte_enable,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_wait_request,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rd_data_vld,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [BE_W-1:0]   reg_byte_enable,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic [DATA_W-1:0] reg_rd_data,
  input  logic              reg_rd_data_vld,
  output logic              timeout_flag,
  input  logic              timeout_clr
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d, gcmd_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_nxt_s;
  logic              gnt_vld_s, gnt_s, update_s;
  logic [1:0]        req_s;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic              m0_wait_q, m0_wait_d, m1_wait_q, m1_wait_d;
  logic              m0_vld_q, m0_vld_d, m1_vld_q, m1_vld_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              tmo_flag_q, tmo_flag_d, tmo_set_s;

  // A dual-strobe command still counts as a request; it becomes a write.
  assign req_s    = {m1_wr_en | m1_rd_en, m0_wr_en | m0_rd_en};
  assign update_s = (state_q == IDLE) & gnt_vld_s;

  rr_arb2 u_rr_arb2 (
    .req_i            (req_s),
    .last_grant_i     (last_grant_q),
    .update_i         (update_s),
    .gnt_vld_o        (gnt_vld_s),
    .gnt_o            (gnt_s),
    .last_grant_nxt_o (last_grant_nxt_s)
  );

  // Mux the granted master's command; write strobe has priority over read.
  always_comb begin
    gcmd_s = '0;
    if (gnt_s) begin
      gcmd_s = '{wr: m1_wr_en, addr: m1_addr, be: m1_byte_enable,
                 data: m1_wr_data, owner: 1'b1};
    end else begin
      gcmd_s = '{wr: m0_wr_en, addr: m0_addr, be: m0_byte_enable,
                 data: m0_wr_data, owner: 1'b0};
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    m0_wait_d  = 1'b1;
    m1_wait_d  = 1'b1;
    m0_vld_d   = 1'b0;
    m1_vld_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    tmo_set_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld_s) begin
          cmd_d     = gcmd_s;
          wr_en_d   = gcmd_s.wr;
          rd_en_d   = ~gcmd_s.wr;
          m0_wait_d = gcmd_s.owner;
          m1_wait_d = ~gcmd_s.owner;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_q.wr) begin
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = '0;
        end
      end
      RD_WAIT: begin
        // Real data beats a timeout that would fire in the same cycle.
        if (reg_rd_data_vld || (cnt_q == CNT_LAST)) begin
          tmo_set_s = ~reg_rd_data_vld;
          state_d   = IDLE;
          if (cmd_q.owner) begin
            m1_vld_d   = 1'b1;
            m1_rdata_d = reg_rd_data_vld ? reg_rd_data : TIMEOUT_DATA;
          end else begin
            m0_vld_d   = 1'b1;
            m0_rdata_d = reg_rd_data_vld ? reg_rd_data : TIMEOUT_DATA;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A timeout in the same cycle as a clear leaves the flag set.
    if (tmo_set_s) begin
      tmo_flag_d = 1'b1;
    end else if (timeout_clr) begin
      tmo_flag_d = 1'b0;
    end else begin
      tmo_flag_d = tmo_flag_q;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      m0_wait_q    <= 1'b1;
      m1_wait_q    <= 1'b1;
      m0_vld_q     <= 1'b0;
      m1_vld_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      tmo_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_nxt_s;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      m0_wait_q    <= m0_wait_d;
      m1_wait_q    <= m1_wait_d;
      m0_vld_q     <= m0_vld_d;
      m1_vld_q     <= m1_vld_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      tmo_flag_q   <= tmo_flag_d;
    end
  end

  assign m0_wait_request = m0_wait_q;
  assign m1_wait_request = m1_wait_q;
  assign m0_rd_data      = m0_rdata_q;
  assign m1_rd_data      = m1_rdata_q;
  assign m0_rd_data_vld  = m0_vld_q;
  assign m1_rd_data_vld  = m1_vld_q;
  assign reg_wr_en       = wr_en_q;
  assign reg_rd_en       = rd_en_q;
  assign reg_addr        = cmd_q.addr;
  assign reg_byte_enable = cmd_q.be;
  assign reg_wr_data     = cmd_q.data;
  assign timeout_flag    = tmo_flag_q;

endmodule

// File: tb/tb_cfg_bus_arb.sv
// Scoreboard bench for cfg_bus_arb: expected slave commands and read
// completions (with the cycle they must appear in) are queued as stimulus
// is driven and checked by a monitor on the falling clock edge.
module tb_cfg_bus_arb;

  localparam int TMO = 8;

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    bit          owner;
    int          cyc;
  } iss_t;

  typedef struct {
    bit          owner;
    logic [31:0] data;
    int          cyc;
  } cpl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_wr_en, m0_rd_en, m1_wr_en, m1_rd_en;
  logic [3:0]  m0_byte_enable, m1_byte_enable, reg_byte_enable;
  logic [13:0] m0_addr, m1_addr, reg_addr;
  logic [31:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
  logic [31:0] reg_wr_data, reg_rd_data;
  logic        m0_wait_request, m1_wait_request;
  logic        m0_rd_data_vld, m1_rd_data_vld;
  logic        reg_wr_en, reg_rd_en, reg_rd_data_vld;
  logic        timeout_flag, timeout_clr;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  iss_t exp_iss[$];
  cpl_t exp_cpl[$];

  cfg_bus_arb #(.TIMEOUT_CYC(TMO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_wr_en(m0_wr_en), .m0_rd_en(m0_rd_en), .m0_byte_enable(m0_byte_enable),
    .m0_addr(m0_addr), .m0_wr_data(m0_wr_data), .m0_wait_request(m0_wait_request),
    .m0_rd_data(m0_rd_data), .m0_rd_data_vld(m0_rd_data_vld),
    .m1_wr_en(m1_wr_en), .m1_rd_en(m1_rd_en), .m1_byte_enable(m1_byte_enable),
    .m1_addr(m1_addr), .m1_wr_data(m1_wr_data), .m1_wait_request(m1_wait_request),
    .m1_rd_data(m1_rd_data), .m1_rd_data_vld(m1_rd_data_vld),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_byte_enable(reg_byte_enable),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
    .reg_rd_data_vld(reg_rd_data_vld), .timeout_flag(timeout_flag),
    .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic m_drive(input int m, input logic wr, input logic rd,
                         input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_wr_en = wr; m0_rd_en = rd; m0_addr = a; m0_wr_data = d; m0_byte_enable = be;
    end else begin
      m1_wr_en = wr; m1_rd_en = rd; m1_addr = a; m1_wr_data = d; m1_byte_enable = be;
    end
  endtask

  task automatic m_idle(input int m);
    m_drive(m, 1'b0, 1'b0, 14'h0000, 32'h0000_0000, 4'h0);
  endtask

  // Returns at the falling edge where the master sees its accept.
  task automatic wait_accept(input int m);
    logic w;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      w = (m == 0) ? m0_wait_request : m1_wait_request;
      n++;
    end while (w && n < 30);
    check_eq($sformatf("accept_m%0d", m), 64'(w), 64'(1'b0));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_w0"},   64'(m0_wait_request), 64'(1'b1));
    check_eq({tag, "_w1"},   64'(m1_wait_request), 64'(1'b1));
    check_eq({tag, "_rd0"},  64'(m0_rd_data), 64'(0));
    check_eq({tag, "_rd1"},  64'(m1_rd_data), 64'(0));
    check_eq({tag, "_vld"},  64'({m1_rd_data_vld, m0_rd_data_vld}), 64'(0));
    check_eq({tag, "_stb"},  64'({reg_wr_en, reg_rd_en}), 64'(0));
    check_eq({tag, "_addr"}, 64'(reg_addr), 64'(0));
    check_eq({tag, "_be"},   64'(reg_byte_enable), 64'(0));
    check_eq({tag, "_wd"},   64'(reg_wr_data), 64'(0));
    check_eq({tag, "_tmo"},  64'(timeout_flag), 64'(0));
  endtask

  // Monitor: compare every slave command and completion pulse against the queues.
  always @(negedge clk) begin
    iss_t e;
    cpl_t c;
    if (reg_wr_en || reg_rd_en) begin
      if (exp_iss.size() == 0) begin
        check_eq("iss_unexp", 64'({reg_wr_en, reg_rd_en}), 64'(0));
      end else begin
        e = exp_iss.pop_front();
        check_eq("iss_cyc",  64'(cyc), 64'(e.cyc));
        check_eq("iss_stb",  64'({reg_wr_en, reg_rd_en}), e.wr ? 64'(2'b10) : 64'(2'b01));
        check_eq("iss_addr", 64'(reg_addr), 64'(e.addr));
        check_eq("iss_be",   64'(reg_byte_enable), 64'(e.be));
        check_eq("iss_data", 64'(reg_wr_data), 64'(e.data));
        check_eq("iss_wait", 64'({m1_wait_request, m0_wait_request}),
                 e.owner ? 64'(2'b01) : 64'(2'b10));
      end
    end else begin
      check_eq("wait_hi", 64'({m1_wait_request, m0_wait_request}), 64'(2'b11));
    end
    if (m0_rd_data_vld || m1_rd_data_vld) begin
      if (exp_cpl.size() == 0) begin
        check_eq("vld_unexp", 64'({m1_rd_data_vld, m0_rd_data_vld}), 64'(0));
      end else begin
        c = exp_cpl.pop_front();
        check_eq("cpl_cyc",  64'(cyc), 64'(c.cyc));
        check_eq("cpl_who",  64'({m1_rd_data_vld, m0_rd_data_vld}),
                 c.owner ? 64'(2'b10) : 64'(2'b01));
        check_eq("cpl_data", 64'(c.owner ? m1_rd_data : m0_rd_data), 64'(c.data));
      end
    end
  end

  // Master process for back-to-back writes.
  task automatic m_burst(input int m, input logic [13:0] base, input logic [31:0] dbase,
                         input logic [3:0] be);
    for (int k = 0; k < 3; k++) begin
      m_drive(m, 1'b1, 1'b0, base + 14'(k), dbase + 32'(k), be);
      wait_accept(m);
      step();
    end
    m_idle(m);
  endtask

  initial begin
    int c, r;
    rst = 1'b1; timeout_clr = 1'b0;
    reg_rd_data = 32'h0; reg_rd_data_vld = 1'b0;
    m_idle(0); m_idle(1);
    step(); step(); step();
    @(negedge clk);
    check_reset_vals("por");
    step(); rst = 1'b0;
    step();

    // M0 single write.
    c = cyc;
    m_drive(0, 1'b1, 1'b0, 14'h0010, 32'h1234_5678, 4'hF);
    exp_iss.push_back('{1'b1, 14'h0010, 4'hF, 32'h1234_5678, 1'b0, c + 1});
    wait_accept(0);
    step(); m_idle(0);

    // M1 read, slave answers one cycle after the strobe.
    c = cyc;
    m_drive(1, 1'b0, 1'b1, 14'h0004, 32'h0, 4'hF);
    exp_iss.push_back('{1'b0, 14'h0004, 4'hF, 32'h0, 1'b1, c + 1});
    exp_cpl.push_back('{1'b1, 32'hCAFE_0001, c + 3});
    wait_accept(1);
    step(); m_idle(1);
    reg_rd_data = 32'hCAFE_0001; reg_rd_data_vld = 1'b1;
    step();
    reg_rd_data = 32'h0; reg_rd_data_vld = 1'b0;
    step();

    // Both masters stream writes from reset: grants alternate M0, M1, ...
    rst = 1'b1;
    m_drive(0, 1'b1, 1'b0, 14'h0100, 32'hA000_0000, 4'hF);
    m_drive(1, 1'b1, 1'b0, 14'h0200, 32'hB000_0000, 4'h3);
    step(); step();
    rst = 1'b0;
    r = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_iss.push_back('{1'b1, 14'h0100 + 14'(k), 4'hF, 32'hA000_0000 + 32'(k), 1'b0, r + 1 + 4 * k});
      exp_iss.push_back('{1'b1, 14'h0200 + 14'(k), 4'h3, 32'hB000_0000 + 32'(k), 1'b1, r + 3 + 4 * k});
    end
    fork
      m_burst(0, 14'h0100, 32'hA000_0000, 4'hF);
      m_burst(1, 14'h0200, 32'hB000_0000, 4'h3);
    join

    // M0 read with no slave response: timeout data TMO+1 cycles after issue.
    c = cyc;
    m_drive(0, 1'b0, 1'b1, 14'h0020, 32'h0, 4'h1);
    exp_iss.push_back('{1'b0, 14'h0020, 4'h1, 32'h0, 1'b0, c + 1});
    exp_cpl.push_back('{1'b0, 32'hDEAD_BEEF, c + 1 + TMO + 1});
    wait_accept(0);
    step(); m_idle(0);
    wait_until(c + TMO + 1);
    @(negedge clk); check_eq("tmo_flag_pre", 64'(timeout_flag), 64'(0));
    @(negedge clk); check_eq("tmo_flag_set", 64'(timeout_flag), 64'(1));
    @(negedge clk); check_eq("tmo_flag_sticky", 64'(timeout_flag), 64'(1));
    step(); timeout_clr = 1'b1;
    step(); timeout_clr = 1'b0;
    @(negedge clk); check_eq("tmo_flag_clr", 64'(timeout_flag), 64'(0));
    step();

    // M1 read timing out while clear is held high: the set wins that cycle.
    timeout_clr = 1'b1;
    c = cyc;
    m_drive(1, 1'b0, 1'b1, 14'h3FF0, 32'h0, 4'h8);
    exp_iss.push_back('{1'b0, 14'h3FF0, 4'h8, 32'h0, 1'b1, c + 1});
    exp_cpl.push_back('{1'b1, 32'hDEAD_BEEF, c + 1 + TMO + 1});
    wait_accept(1);
    step(); m_idle(1);
    wait_until(c + TMO + 2);
    @(negedge clk); check_eq("tmo_set_wins", 64'(timeout_flag), 64'(1));
    @(negedge clk); check_eq("tmo_clr_after", 64'(timeout_flag), 64'(0));
    step(); timeout_clr = 1'b0;

    // Reset during RD_WAIT, then a late slave valid.
    c = cyc;
    m_drive(1, 1'b0, 1'b1, 14'h0030, 32'h0, 4'hF);
    exp_iss.push_back('{1'b0, 14'h0030, 4'hF, 32'h0, 1'b1, c + 1});
    wait_accept(1);
    step(); m_idle(1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    reg_rd_data = 32'h5555_AAAA; reg_rd_data_vld = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    step(); reg_rd_data_vld = 1'b0; reg_rd_data = 32'h0;
    repeat (TMO + 4) step();
    @(negedge clk);
    check_reset_vals("midrst_late");

    // Stray valid in IDLE, then a dual-strobe command that must act as a write.
    step();
    reg_rd_data = 32'h7777_0000; reg_rd_data_vld = 1'b1;
    step();
    reg_rd_data_vld = 1'b0;
    c = cyc;
    m_drive(0, 1'b1, 1'b1, 14'h3FFF, 32'h0F0F_0F0F, 4'h5);
    exp_iss.push_back('{1'b1, 14'h3FFF, 4'h5, 32'h0F0F_0F0F, 1'b0, c + 1});
    wait_accept(0);
    step(); m_idle(0);
    reg_rd_data_vld = 1'b1;
    step();
    reg_rd_data_vld = 1'b0; reg_rd_data = 32'h0;
    repeat (TMO + 4) step();

    check_eq("iss_left", 64'(exp_iss.size()), 64'(0));
    check_eq("cpl_left", 64'(exp_cpl.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
